// File: rtl/fir_coeff_programmer_pkg.sv
// Shared types and defaults for the FIR coefficient write-side programmer.
package fir_coeff_programmer_pkg;

  localparam int DEF_NUM_COEFF  = 4;
  localparam int DEF_SIZE       = 8;
  localparam int DEF_COEFF_BITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FIN   = 2'd2
  } prog_state_e;

endpackage

// File: rtl/fir_coeff_programmer_sat.sv
// Clamps a SIZE-bit coefficient to COEFF_BITS unsigned bits, zero-extended
// back to SIZE; ovf flags any set bit above the payload. Combinational.
module fir_coeff_programmer_sat #(
  parameter int SIZE       = 8,
  parameter int COEFF_BITS = 5
) (
  input  logic [SIZE-1:0] coeff_in,
  output logic [SIZE-1:0] coeff_out,
  output logic            ovf
);

  generate
    if (COEFF_BITS < SIZE) begin : g_clamp
      always_comb begin
        ovf       = |coeff_in[SIZE-1:COEFF_BITS];
        coeff_out = '0;
        coeff_out[COEFF_BITS-1:0] = ovf ? {COEFF_BITS{1'b1}} : coeff_in[COEFF_BITS-1:0];
      end
    end else begin : g_pass
      always_comb begin
        ovf       = 1'b0;
        coeff_out = coeff_in;
      end
    end
  endgenerate

endmodule

// File: rtl/fir_coeff_programmer.sv
// Captures a packed coefficient set on valid/ready, then writes it into the
// coefficient register file one index per cycle (sel 0 first), pulsing done.
module fir_coeff_programmer
  import fir_coeff_programmer_pkg::*;
#(
  parameter int  NUM_COEFF  = DEF_NUM_COEFF,
  parameter int  SIZE       = DEF_SIZE,
  parameter int  COEFF_BITS = DEF_COEFF_BITS,
  localparam int SEL_W      = $clog2(NUM_COEFF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic [NUM_COEFF*SIZE-1:0] coeffs_in,
  input  logic                      abort,
  output logic [SIZE-1:0]           wr_coeff,
  output logic [SEL_W-1:0]          wr_sel,
  output logic                      wr_en,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  output logic                      sat_err
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_COEFF - 1);

  prog_state_e               state_q, state_d;
  logic [SEL_W-1:0]          idx_q, idx_d;
  logic [NUM_COEFF*SIZE-1:0] hold_q, hold_d;
  logic                      load_ready_q, load_ready_d;
  logic                      wr_en_q, wr_en_d;
  logic [SEL_W-1:0]          wr_sel_q, wr_sel_d;
  logic [SIZE-1:0]           wr_coeff_q, wr_coeff_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      aborted_q, aborted_d;
  logic                      sat_err_q, sat_err_d;

  logic                      accept;
  logic [SEL_W-1:0]          nxt_idx;
  logic [SIZE-1:0]           sat_in, sat_out;
  logic                      sat_ovf;

  assign accept  = (state_q == ST_IDLE) && load_valid && load_ready_q;
  assign nxt_idx = accept ? '0 : idx_q + 1'b1;
  // The first word comes straight from the input; the hold register is loaded at the same edge.
  assign sat_in  = accept ? coeffs_in[SIZE-1:0] : hold_q[int'(nxt_idx)*SIZE +: SIZE];

  fir_coeff_programmer_sat #(
    .SIZE       (SIZE),
    .COEFF_BITS (COEFF_BITS)
  ) u_sat (
    .coeff_in  (sat_in),
    .coeff_out (sat_out),
    .ovf       (sat_ovf)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hold_d       = hold_q;
    load_ready_d = 1'b0;
    wr_en_d      = 1'b0;
    wr_sel_d     = '0;
    wr_coeff_d   = '0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    sat_err_d    = sat_err_q;
    case (state_q)
      ST_IDLE: begin
        load_ready_d = 1'b1;
        if (accept) begin
          state_d      = ST_WRITE;
          idx_d        = '0;
          hold_d       = coeffs_in;
          load_ready_d = 1'b0;
          busy_d       = 1'b1;
          wr_en_d      = 1'b1;
          wr_sel_d     = nxt_idx;
          wr_coeff_d   = sat_out;
          sat_err_d    = sat_ovf;
        end
      end
      ST_WRITE: begin
        // idx_q is the write on the bus now; abort suppresses the one after it.
        if (abort) begin
          state_d      = ST_IDLE;
          aborted_d    = 1'b1;
          load_ready_d = 1'b1;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b1;
        end else begin
          idx_d      = nxt_idx;
          busy_d     = 1'b1;
          wr_en_d    = 1'b1;
          wr_sel_d   = nxt_idx;
          wr_coeff_d = sat_out;
          sat_err_d  = sat_err_q | sat_ovf;
        end
      end
      ST_FIN: begin
        state_d      = ST_IDLE;
        load_ready_d = 1'b1;
      end
      default: begin
        state_d      = ST_IDLE;
        load_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      hold_q       <= '0;
      load_ready_q <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_sel_q     <= '0;
      wr_coeff_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      sat_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hold_q       <= hold_d;
      load_ready_q <= load_ready_d;
      wr_en_q      <= wr_en_d;
      wr_sel_q     <= wr_sel_d;
      wr_coeff_q   <= wr_coeff_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      sat_err_q    <= sat_err_d;
    end
  end

  assign load_ready = load_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_sel     = wr_sel_q;
  assign wr_coeff   = wr_coeff_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign sat_err    = sat_err_q;

endmodule
